program_loader: RTL

Serial program-memory writer: the write side of the instruction memory that the program counter fetches from. It receives 16-bit instruction words over a 3-wire serial link (chip select, serial clock, data), synchronizes them into the `i_clk` domain and issues single-cycle write strobes with an auto-incrementing address into program RAM. It sits beside the program counter in `top`; `o_busy` holds the CPU while a load is in progress, so a program can be replaced without re-synthesizing the hex image.

---
 rtl/program_loader_pkg.sv | 17 +
 rtl/program_loader_sync_edge.sv | 49 ++++
 rtl/program_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the serial program-memory writer: the loader FSM
// state encoding and the default instruction word width.
// -----------------------------------------------------------------------------
package program_loader_pkg;

    localparam int INST_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2,
        ST_DRAIN = 2'd3
    } load_state_t;

endpackage

// File: rtl/program_loader_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for one asynchronous input followed by an edge
// register, producing the synchronized level plus single-cycle rise/fall
// pulses in the i_clk domain.
//
// Ports:
//   i_clk     system clock
//   i_reset   synchronous active-high reset (edge register only)
//   i_async   asynchronous input pin
//   o_level   synchronized level
//   o_rise    one-cycle pulse on a synchronized 0->1 transition
//   o_fall    one-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic meta;
    logic sync;
    logic prev;

    // The synchronizer stages keep sampling during reset so that o_level
    // reflects the real pin as soon as reset is released.
    always_ff @(posedge i_clk) begin
        meta <= i_async;
        sync <= meta;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev <= RESET_VAL;
        end else begin
            prev <= sync;
        end
    end

    assign o_level = sync;
    assign o_rise  = sync & ~prev;
    assign o_fall  = ~sync & prev;

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Serial program-memory writer. Receives DATA_WIDTH-bit words MSB first over
// a chip-select / serial-clock / data link, synchronizes them into i_clk and
// issues single-cycle write strobes with an auto-incrementing address.
//
// Ports:
//   i_clk, i_reset   system clock, synchronous active-high reset
//   i_cs_n           frame select (async, active low)
//   i_sclk           serial clock (async), data sampled on rising edge
//   i_sdata          serial data, MSB first
//   o_wr_en          one-cycle write strobe
//   o_wr_addr        write address (held outside WRITE)
//   o_wr_data        write data (held outside WRITE)
//   o_busy           frame in progress
//   o_done           last frame ended cleanly (sticky)
//   o_error          last frame malformed or overflowed (sticky)
//   o_word_count     words written in the current or last frame
// -----------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = INST_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cs_n,
    input  logic                  i_sclk,
    input  logic                  i_sdata,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH:0]   o_word_count
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] BIT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic sdata_level, sdata_rise, sdata_fall;
    logic unused_edges;

    load_state_t           state;
    logic [DATA_WIDTH-2:0] shift_reg;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  armed;

    sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_cs_n),
        .o_level (cs_level),
        .o_rise  (cs_rise),
        .o_fall  (cs_fall)
    );

    sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_sclk),
        .o_level (sclk_level),
        .o_rise  (sclk_rise),
        .o_fall  (sclk_fall)
    );

    sync_edge #(.RESET_VAL(1'b0)) u_sync_sdata (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_sdata),
        .o_level (sdata_level),
        .o_rise  (sdata_rise),
        .o_fall  (sdata_fall)
    );

    assign unused_edges = ^{sclk_level, sclk_fall, sdata_rise, sdata_fall};

    // Loader FSM. A new frame needs cs_n to have been seen high since reset
    // ("armed"), so a select held low across reset never starts a frame even
    // though the edge register comes out of reset high. Overflow is detected
    // with the top bit of the word count: once 2^ADDR_WIDTH words are written
    // the address is saturated and further words are refused.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            addr         <= '0;
            armed        <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_word_count <= '0;
        end else begin
            o_wr_en <= 1'b0;
            if (cs_level) begin
                armed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (cs_fall && armed) begin
                        state        <= ST_SHIFT;
                        addr         <= '0;
                        o_word_count <= '0;
                        bit_cnt      <= '0;
                        o_done       <= 1'b0;
                        o_error      <= 1'b0;
                        o_busy       <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // cs_n rise has priority over a coincident sclk rise
                    if (cs_rise) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                        if (bit_cnt == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            o_error <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[DATA_WIDTH-3:0], sdata_level};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (o_word_count[ADDR_WIDTH]) begin
                                o_error <= 1'b1;
                                state   <= ST_DRAIN;
                            end else begin
                                o_wr_en   <= 1'b1;
                                o_wr_addr <= addr;
                                o_wr_data <= {shift_reg, sdata_level};
                                state     <= ST_WRITE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    o_word_count <= o_word_count + 1'b1;
                    if (~&addr) begin
                        addr <= addr + 1'b1;
                    end
                    bit_cnt <= '0;
                    if (cs_rise) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else begin
                        state <= ST_SHIFT;
                    end
                end
                ST_DRAIN: begin
                    if (cs_rise) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
